// File: rtl/bram_dp.sv
// ----------------------------------------------------------------------------
// bram_dp -- true dual-port, byte-writable block RAM with a zero-fill engine.
//
// Two symmetric ports (A, B) each read one word and write any subset of its
// byte lanes per cycle. Port A wins overlapping lanes when both ports write the
// same word; a one-cycle collision flag reports that case. A clear engine owns
// the array after reset and on clear_req_i, writing zero to every word in turn.
//
// Parameters
//   BRAM_WIDTH    data width in bits (8 * WORD_SIZE)
//   BRAM_SIZE     capacity in bytes
//   WORD_SIZE     bytes per word, one write enable per byte
//   ADDR_WIDTH    byte address width (log2(BRAM_SIZE))
//   READ_LATENCY  1 or 2 cycles from access to read data
//   WRITE_MODE    same-port read-during-write: 0 read-first, 1 write-first
//
// Ports
//   clk_i                    clock, rising edge
//   reset_i                  asynchronous active-high reset
//   clear_req_i              pulse: zero-fill the whole array
//   a_en_i / b_en_i          port access enable
//   a_addr_i / b_addr_i      byte address (low log2(WORD_SIZE) bits ignored)
//   a_wrdata_i / b_wrdata_i  write data
//   a_we_i / b_we_i          per-byte write enables
//   a_rddata_o / b_rddata_o  read data
//   busy_o                   clear engine owns the array
//   collision_o              previous cycle had an overlapping same-word dual write
// ----------------------------------------------------------------------------
module bram_dp #(
    parameter int unsigned BRAM_WIDTH   = 32,
    parameter int unsigned BRAM_SIZE    = 4096,
    parameter int unsigned WORD_SIZE    = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRITE_MODE   = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_req_i,
    input  logic                  a_en_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [BRAM_WIDTH-1:0] a_wrdata_i,
    input  logic [WORD_SIZE-1:0]  a_we_i,
    output logic [BRAM_WIDTH-1:0] a_rddata_o,
    input  logic                  b_en_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [BRAM_WIDTH-1:0] b_wrdata_i,
    input  logic [WORD_SIZE-1:0]  b_we_i,
    output logic [BRAM_WIDTH-1:0] b_rddata_o,
    output logic                  busy_o,
    output logic                  collision_o
);

    localparam int unsigned NUM_WORDS = BRAM_SIZE / WORD_SIZE;
    localparam int unsigned ADDR_LSB  = $clog2(WORD_SIZE);
    localparam int unsigned IDX_W     = ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    // Overlay the bytes enabled by we onto old.
    function automatic logic [BRAM_WIDTH-1:0] merge_lanes(
        input logic [BRAM_WIDTH-1:0] old,
        input logic [BRAM_WIDTH-1:0] nw,
        input logic [WORD_SIZE-1:0]  we
    );
        logic [BRAM_WIDTH-1:0] res;
        res = old;
        for (int i = 0; i < int'(WORD_SIZE); i++) begin
            if (we[i]) begin
                res[i*8 +: 8] = nw[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Storage (deliberately not reset; the clear engine zeroes it)
    // ------------------------------------------------------------------
    logic [BRAM_WIDTH-1:0] mem_q [NUM_WORDS];

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             busy;

    logic [IDX_W-1:0] a_idx, b_idx;
    logic             a_acc, b_acc;
    logic [BRAM_WIDTH-1:0] a_old, b_old;
    logic [BRAM_WIDTH-1:0] a_rd_word, b_rd_word;

    // Only the word index is used; the byte offset is intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{a_addr_i, b_addr_i};

    assign busy   = (state_q == StClear);
    assign busy_o = busy;

    assign a_idx = a_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign b_idx = b_addr_i[ADDR_WIDTH-1:ADDR_LSB];

    // Ports are locked out entirely while the clear engine runs.
    assign a_acc = a_en_i & ~busy;
    assign b_acc = b_en_i & ~busy;

    // Reads see the array before this cycle's writes land, which gives
    // read-first behaviour for both same-port and cross-port accesses.
    assign a_old = mem_q[a_idx];
    assign b_old = mem_q[b_idx];

    // Write-first only merges the port's own write, never the other port's.
    assign a_rd_word = (WRITE_MODE == 1) ? merge_lanes(a_old, a_wrdata_i, a_we_i) : a_old;
    assign b_rd_word = (WRITE_MODE == 1) ? merge_lanes(b_old, b_wrdata_i, b_we_i) : b_old;

    // ------------------------------------------------------------------
    // Array write: clear engine, else port B then port A so that A's
    // later non-blocking assignment wins overlapping lanes of one word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (b_acc) begin
                for (int i = 0; i < int'(WORD_SIZE); i++) begin
                    if (b_we_i[i]) begin
                        mem_q[b_idx][i*8 +: 8] <= b_wrdata_i[i*8 +: 8];
                    end
                end
            end
            if (a_acc) begin
                for (int i = 0; i < int'(WORD_SIZE); i++) begin
                    if (a_we_i[i]) begin
                        mem_q[a_idx][i*8 +: 8] <= a_wrdata_i[i*8 +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Clear engine FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clear_req_i) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end
            end
            StClear: begin
                // Hold at the terminal count rather than wrapping.
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Reset parks the engine in StClear so the zero-fill starts on release.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Collision flag
    // ------------------------------------------------------------------
    logic collision_q, collision_d;

    assign collision_d = a_acc & b_acc & (a_idx == b_idx) & (|(a_we_i & b_we_i));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision_o = collision_q;

    // ------------------------------------------------------------------
    // Read pipeline, first stage (loads only on an accepted access)
    // ------------------------------------------------------------------
    logic [BRAM_WIDTH-1:0] a_rd1_q, b_rd1_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            a_rd1_q <= '0;
            b_rd1_q <= '0;
        end else begin
            if (a_acc) begin
                a_rd1_q <= a_rd_word;
            end
            if (b_acc) begin
                b_rd1_q <= b_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional second stage: advances only the cycle after a first-stage
    // load, so an idle port holds every stage.
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  a_vld_q, b_vld_q;
        logic [BRAM_WIDTH-1:0] a_rd2_q, b_rd2_q;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                a_vld_q <= 1'b0;
                b_vld_q <= 1'b0;
                a_rd2_q <= '0;
                b_rd2_q <= '0;
            end else begin
                a_vld_q <= a_acc;
                b_vld_q <= b_acc;
                if (a_vld_q) begin
                    a_rd2_q <= a_rd1_q;
                end
                if (b_vld_q) begin
                    b_rd2_q <= b_rd1_q;
                end
            end
        end

        assign a_rddata_o = a_rd2_q;
        assign b_rddata_o = b_rd2_q;
    end else begin : g_lat1
        assign a_rddata_o = a_rd1_q;
        assign b_rddata_o = b_rd1_q;
    end

endmodule

// File: doc/bram_dp.md
BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 Parameter BRAM_WIDTH, 32: read/write data width in bits; SHALL equal 8*WORD_SIZE.
REQ-002 Parameter BRAM_SIZE, 4096: capacity in bytes.
REQ-003 Parameter WORD_SIZE, 4: bytes per word, one write-enable bit per byte.
REQ-004 Parameter ADDR_WIDTH, 12: byte-address width; SHALL equal log2(BRAM_SIZE).
REQ-005 Parameter READ_LATENCY, 1: cycles from accepted read to valid rddata; legal values 1 or 2.
REQ-006 Parameter WRITE_MODE, 0: same-port read-during-write; 0 = read-first (old data), 1 = write-first (new data).
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 clear_req  input  1  one-cycle pulse requesting a full zero-fill of memory.
REQ-010 a_en / b_en  input  1 each  port access enable.
REQ-011 a_addr / b_addr  input  ADDR_WIDTH each  byte address; word index = addr[ADDR_WIDTH-1:log2(WORD_SIZE)]; low bits ignored.
REQ-012 a_wrdata / b_wrdata  input  BRAM_WIDTH each  write data.
REQ-013 a_we / b_we  input  WORD_SIZE each  per-byte write enables; any pattern legal.
REQ-014 a_rddata / b_rddata  output  BRAM_WIDTH each  read data.
REQ-015 busy  output  1  high while the clear engine owns the array.
REQ-016 collision  output  1  one-cycle flag for a same-word, overlapping-lane dual write.

Function
REQ-017 Array SHALL hold BRAM_SIZE/WORD_SIZE words; no reset on array storage.
REQ-018 A port with en=1 and busy=0 SHALL read the addressed word each cycle and write every byte lane whose we bit is 1.
REQ-019 READ_LATENCY=1: rddata valid the cycle after the access; READ_LATENCY=2: one extra output register stage, valid two cycles after.
REQ-020 With en=0, a port's rddata SHALL hold its last value (every pipeline stage holds).
REQ-021 Same-port read and write of one word: WRITE_MODE=0 returns pre-write word; WRITE_MODE=1 returns merged word (new bytes where we=1, old elsewhere).
REQ-022 Cross-port read of a word written by the other port in the same cycle SHALL return the pre-write word regardless of WRITE_MODE.
REQ-023 Both ports writing the same word in one cycle: port A SHALL win on overlapping lanes, each port's non-overlapping lanes written normally.
REQ-024 collision SHALL be 1 exactly one cycle after any cycle meeting REQ-023 with a_we & b_we != 0; otherwise 0.
REQ-025 Clear engine FSM states: IDLE, CLEAR.
REQ-026 IDLE -> CLEAR on reset deassertion (first clk edge after reset falls) or on clear_req=1 in IDLE.
REQ-027 CLEAR: writes zero to word index 0,1,...,NUM_WORDS-1, one per cycle, via an internal counter; returns to IDLE the cycle after writing the last word (clear takes NUM_WORDS cycles).
REQ-028 busy=1 in CLEAR, 0 in IDLE; clear_req while in CLEAR SHALL be ignored.
REQ-029 While busy=1, port writes SHALL be dropped, port reads SHALL not be performed, rddata SHALL hold, collision SHALL stay 0.
REQ-030 Clear counter SHALL not wrap; the terminal count is NUM_WORDS-1.

Reset
REQ-031 reset=1 SHALL immediately force a_rddata=0, b_rddata=0 (all pipeline stages), collision=0, clear counter=0, state=CLEAR, busy=1.
REQ-032 Reset asserted mid-clear SHALL restart the clear from word 0 after deassertion.
REQ-033 Reset asserted mid-access SHALL discard in-flight reads; memory contents after reset are defined only once busy falls (all zero).

Verification
REQ-034 Reset, release -> busy=1 for exactly NUM_WORDS (1024) cycles, then 0; read every word on both ports -> all 0x00000000.
REQ-035 Port A write 0xDEADBEEF to addr 0x010 we=4'hF, then we=4'b0010 with 0x0000AA00 -> port B read of 0x010 returns 0xDEADAAEF after READ_LATENCY cycles (run for latency 1 and 2).
REQ-036 Same cycle A write 0x11111111 we=4'b0011, B write 0x22222222 we=4'b0110 to addr 0x020 -> collision=1 next cycle only; word reads 0x00221111.
REQ-037 Port A read+write addr 0x030 (old 0x0, new 0x5) -> a_rddata=0x0 with WRITE_MODE=0, 0x5 with WRITE_MODE=1; port B reading 0x030 that cycle returns 0x0 in both.
REQ-038 clear_req mid-traffic with memory nonzero -> busy for 1024 cycles, writes during busy dropped, all words 0 after; reset asserted at clear cycle 500 -> clear restarts, busy 1024 cycles after release.
